// File: rtl/synapse_current.sv
// Post-synaptic current generator: captures pre-synaptic spikes, delays them by
// DELAY simulation steps, and integrates signed weights into a decaying current.
module synapse_current #(
  parameter int unsigned DELAY       = 2,
  parameter int unsigned DECAY_SHIFT = 3,
  parameter int          BIAS        = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  input  logic        spike_in,
  input  logic [10:0] weight,
  output logic [10:0] i_out,
  output logic        spike_del,
  output logic        sat,
  input  logic        sat_clr,
  output logic [15:0] spike_cnt
);

  localparam int unsigned IW = 11;
  localparam int unsigned SW = 14;

  logic                 r_pending;
  logic                 w_cap;
  logic                 w_del;
  logic signed [IW-1:0] r_i;
  logic                 r_spike_del;
  logic                 r_sat;
  logic [15:0]          r_cnt;

  logic signed [SW-1:0] w_cur;
  logic signed [SW-1:0] w_dec;
  logic signed [SW-1:0] w_wt;
  logic signed [SW-1:0] w_bias;
  logic signed [SW-1:0] w_sum;
  logic signed [IW-1:0] w_next;
  logic                 w_clamp;

  // Spikes between steps merge; a spike on the step cycle belongs to that step.
  assign w_cap = r_pending | spike_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending <= 1'b0;
    end else if (step) begin
      r_pending <= 1'b0;
    end else if (spike_in) begin
      r_pending <= 1'b1;
    end
  end

  // Axonal delay line, advanced once per simulation step.
  if (DELAY > 0) begin : g_line
    logic [DELAY-1:0] r_line;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_line <= '0;
      end else if (step) begin
        r_line <= DELAY'({r_line, w_cap});
      end
    end

    assign w_del = r_line[DELAY-1];
  end else begin : g_nodelay
    assign w_del = w_cap;
  end

  // Decay, weight and bias summed at 14 bits so the clamp sees the true value.
  assign w_cur  = {{(SW-IW){r_i[IW-1]}}, r_i};
  assign w_dec  = w_cur >>> DECAY_SHIFT;
  assign w_wt   = w_del ? {{(SW-IW){weight[IW-1]}}, weight} : '0;
  assign w_bias = SW'(BIAS);
  assign w_sum  = w_cur - w_dec + w_wt + w_bias;

  always_comb begin
    w_next  = w_sum[IW-1:0];
    w_clamp = 1'b0;
    if (w_sum > 14'sd1023) begin
      w_next  = 11'sd1023;
      w_clamp = 1'b1;
    end else if (w_sum < -14'sd1024) begin
      w_next  = 11'h400;
      w_clamp = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_i         <= '0;
      r_spike_del <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_spike_del <= step & w_del;
      if (step) begin
        r_i <= w_next;
        if (w_del) begin
          r_cnt <= r_cnt + 16'd1;
        end
      end
    end
  end

  // Sticky saturation flag; a saturating step overrides a simultaneous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sat <= 1'b0;
    end else if (step && w_clamp) begin
      r_sat <= 1'b1;
    end else if (sat_clr) begin
      r_sat <= 1'b0;
    end
  end

  assign i_out     = r_i;
  assign spike_del = r_spike_del;
  assign sat       = r_sat;
  assign spike_cnt = r_cnt;

endmodule

// File: tb/tb_synapse_current.sv
// Directed bench for synapse_current: three instances (DELAY 2, 0, 1) share stimulus.
module tb_synapse_current;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        step = 1'b0;
  logic        spike_in = 1'b0;
  logic        sat_clr = 1'b0;
  logic [10:0] weight = '0;

  logic [10:0] i2, i0, i1;
  logic        del2, del0, del1;
  logic        sat2, sat0, sat1;
  logic [15:0] cnt2, cnt0, cnt1;

  int checks = 0;
  int failures = 0;

  synapse_current #(.DELAY(2), .DECAY_SHIFT(3), .BIAS(0)) u_d2 (
    .clk(clk), .rst(rst), .step(step), .spike_in(spike_in), .weight(weight),
    .i_out(i2), .spike_del(del2), .sat(sat2), .sat_clr(sat_clr), .spike_cnt(cnt2)
  );

  synapse_current #(.DELAY(0), .DECAY_SHIFT(3), .BIAS(0)) u_d0 (
    .clk(clk), .rst(rst), .step(step), .spike_in(spike_in), .weight(weight),
    .i_out(i0), .spike_del(del0), .sat(sat0), .sat_clr(sat_clr), .spike_cnt(cnt0)
  );

  synapse_current #(.DELAY(1), .DECAY_SHIFT(3), .BIAS(0)) u_d1 (
    .clk(clk), .rst(rst), .step(step), .spike_in(spike_in), .weight(weight),
    .i_out(i1), .spike_del(del1), .sat(sat1), .sat_clr(sat_clr), .spike_cnt(cnt1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input int exp);
    checks++;
    assert (int'(obs) === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input logic signed [10:0] obs, input int exp);
    checks++;
    assert (int'(obs) === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_step(input logic spk);
    step = 1'b1;
    spike_in = spk;
    tick();
    step = 1'b0;
    spike_in = 1'b0;
  endtask

  task automatic pulse();
    spike_in = 1'b1;
    tick();
    spike_in = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #3;
    rst = 1'b1;
    tick();
  endtask

  initial begin
    logic signed [10:0] prev;
    logic done;
    prev = '0;
    done = 1'b0;

    #12 rst = 1'b1;
    tick();
    chki("reset_i_out", i2, 0);
    chk("reset_cnt", cnt2, 0);
    chk("reset_sat", 16'(sat2), 0);

    // Delay 2 / decay 3: spike before S1 delivered at S3.
    weight = 11'(200);
    pulse();
    do_step(1'b0);
    chk("d2_s1_del", 16'(del2), 0);
    do_step(1'b0);
    chk("d2_s2_del", 16'(del2), 0);
    chki("d2_s2_i", i2, 0);
    do_step(1'b0);
    chk("d2_s3_del", 16'(del2), 1);
    chki("d2_s3_i", i2, 200);
    tick();
    chk("d2_pulse_one_cycle", 16'(del2), 0);
    chki("d2_hold_i", i2, 200);
    do_step(1'b0);
    chki("d2_s4_i", i2, 175);
    do_step(1'b0);
    chki("d2_s5_i", i2, 154);
    chk("d2_cnt", cnt2, 1);
    repeat (60) do_step(1'b0);
    chki("d2_stall_7", i2, 7);

    // Reset mid-operation with i_out=300 and spikes in flight.
    do_reset();
    weight = 11'(300);
    pulse();
    do_step(1'b1);
    do_step(1'b1);
    do_step(1'b1);
    chki("rst_pre_i", i2, 300);
    pulse();
    #2 rst = 1'b0;
    #1;
    chki("rst_async_i", i2, 0);
    chk("rst_async_cnt", cnt2, 0);
    chk("rst_async_sat", 16'(sat2), 0);
    #2 rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      do_step(1'b0);
      chk("rst_no_del", 16'(del2), 0);
    end
    chki("rst_post_i", i2, 0);

    // Positive saturation, DELAY=0.
    do_reset();
    weight = 11'(1000);
    do_step(1'b1);
    chki("pos_s1_i", i0, 1000);
    chk("pos_s1_sat", 16'(sat0), 0);
    do_step(1'b1);
    chki("pos_s2_i", i0, 1023);
    chk("pos_s2_sat", 16'(sat0), 1);
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    chk("pos_clr_sat", 16'(sat0), 0);
    chki("pos_clr_i", i0, 1023);
    sat_clr = 1'b1;
    do_step(1'b1);
    sat_clr = 1'b0;
    chk("pos_set_wins", 16'(sat0), 1);
    chki("pos_s3_i", i0, 1023);

    // Negative saturation and decay toward zero.
    do_reset();
    weight = 11'(-600);
    do_step(1'b1);
    chki("neg_s1_i", i0, -600);
    do_step(1'b1);
    chki("neg_s2_i", i0, -1024);
    chk("neg_s2_sat", 16'(sat0), 1);
    do_step(1'b0);
    chki("neg_s3_i", i0, -896);
    do_step(1'b0);
    chki("neg_s4_i", i0, -784);
    for (int k = 0; k < 300 && !done; k++) begin
      prev = i0;
      do_step(1'b0);
      if (i0 == '0) done = 1'b1;
    end
    chk("neg_reach_zero", 16'(done), 1);
    chki("neg_last_nonzero", prev, -1);

    // Merge and coincidence, DELAY=1.
    do_reset();
    weight = 11'(100);
    do_step(1'b0);
    pulse();
    tick();
    pulse();
    pulse();
    tick();
    do_step(1'b0);
    chk("mrg_s2_del", 16'(del1), 0);
    do_step(1'b0);
    chk("mrg_s3_del", 16'(del1), 1);
    chki("mrg_s3_i", i1, 100);
    chk("mrg_s3_cnt", cnt1, 1);
    tick();
    do_step(1'b1);
    chk("coin_s4_del", 16'(del1), 0);
    chki("coin_s4_i", i1, 88);
    tick();
    do_step(1'b0);
    chk("coin_s5_del", 16'(del1), 1);
    chki("coin_s5_i", i1, 177);
    chk("coin_s5_cnt", cnt1, 2);
    tick();
    do_step(1'b0);
    chk("coin_s6_del", 16'(del1), 0);
    chk("coin_s6_cnt", cnt1, 2);
    chki("coin_s6_i", i1, 155);

    // Counter wrap: spike on every consecutive step, weight 5 settles at 40.
    do_reset();
    weight = 11'(5);
    step = 1'b1;
    spike_in = 1'b1;
    repeat (65535) tick();
    chk("wrap_max", cnt0, 65535);
    chki("wrap_pre_i", i0, 40);
    tick();
    step = 1'b0;
    spike_in = 1'b0;
    chk("wrap_zero", cnt0, 0);
    chki("wrap_post_i", i0, 40);
    chk("wrap_del", 16'(del0), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
